usb_slavefifo_responder: RTL

- Synthesizable, cycle-accurate model of the FX2 side of the synchronous slave-FIFO link.
- FPGA-side logic drives `nSLRD`/`nSLOE`/`nSLWR`/`nPKTEND`/`FIFOADR`; this block answers on `FD_BUS` and `FLAGA`/`FLAGB`/`FLAGC`.
- Contains an EP2 OUT buffer (host→FPGA control words) and an EP6 IN buffer (FPGA→host acquisition data with packet commit).
- Used for on-board loopback and system-level simulation of the DAQ readout path, replacing the USB chip.

---
 rtl/usb_slavefifo_responder.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/usb_slavefifo_responder.sv
// FX2 slave-FIFO responder: EP2 OUT control buffer and EP6 IN data buffer
// with packet commit. Optional macro: USB_SLAVEFIFO_RESP_SWAP_EN (EP6 byte swap).
module usb_slavefifo_responder #(
    parameter int EP2_AW    = 8,
    parameter int EP6_AW    = 10,
    parameter int PKT_WORDS = 256
) (
    input  logic              IFCLK,
    input  logic              nRST,
    input  logic              nSLCS,
    input  logic              nSLOE,
    input  logic              nSLRD,
    input  logic              nSLWR,
    input  logic              nPKTEND,
    input  logic [1:0]        FIFOADR,
    inout  wire  [15:0]       FD_BUS,
    output logic              FLAGA,
    output logic              FLAGB,
    output logic              FLAGC,
    input  logic              host_ep2_wr_en,
    input  logic [15:0]       host_ep2_din,
    output logic              host_ep2_full,
    input  logic              host_ep6_rd_en,
    output logic [15:0]       host_ep6_dout,
    output logic              host_ep6_valid,
    output logic [EP6_AW:0]   host_ep6_committed,
    output logic              err_ep6_ovf,
    output logic              err_ep2_udf
);

    localparam logic [EP2_AW:0] EP2_DEPTH = (EP2_AW+1)'(1 << EP2_AW);
    localparam logic [EP6_AW:0] EP6_DEPTH = (EP6_AW+1)'(1 << EP6_AW);
    localparam logic [EP6_AW:0] PKT_W     = (EP6_AW+1)'(PKT_WORDS);

    logic [15:0]       ep2_mem [EP2_DEPTH];
    logic [EP2_AW-1:0] ep2_wp;
    logic [EP2_AW-1:0] ep2_rp;
    logic [EP2_AW:0]   ep2_cnt;

    logic [15:0]       ep6_mem [EP6_DEPTH];
    logic [EP6_AW-1:0] ep6_wp;
    logic [EP6_AW-1:0] ep6_rp;
    logic [EP6_AW:0]   ep6_cnt;
    logic [EP6_AW:0]   ep6_cmt;

    logic        sel_ep2;
    logic        sel_ep6;
    logic        ep2_oe;
    logic        ep2_rd;
    logic        ep2_empty;
    logic        ep2_full;
    logic        ep2_pop;
    logic        ep2_push;
    logic [15:0] ep2_bus;

    logic        ep6_full;
    logic        ep6_wr;
    logic        ep6_wr_ok;
    logic        ep6_pkt;
    logic        ep6_pop;
    logic [15:0] ep6_din;
    logic [EP6_AW:0] ep6_unc;
    logic [EP6_AW:0] ep6_unc_after;
    logic [EP6_AW:0] ep6_add;

    assign sel_ep2 = !nSLCS && (FIFOADR == 2'b00);
    assign sel_ep6 = !nSLCS && (FIFOADR == 2'b10);

    assign ep2_empty = (ep2_cnt == '0);
    assign ep2_full  = (ep2_cnt == EP2_DEPTH);
    assign ep2_oe    = sel_ep2 && !nSLOE;
    assign ep2_rd    = sel_ep2 && !nSLRD;
    assign ep2_pop   = ep2_rd && !ep2_empty;
    assign ep2_push  = host_ep2_wr_en && !ep2_full;
    assign ep2_bus   = ep2_empty ? 16'h0000 : ep2_mem[ep2_rp];

    assign FD_BUS = ep2_oe ? ep2_bus : 16'hzzzz;

`ifdef USB_SLAVEFIFO_RESP_SWAP_EN
    assign ep6_din = {FD_BUS[7:0], FD_BUS[15:8]};
`else
    assign ep6_din = FD_BUS;
`endif

    assign ep6_full      = (ep6_cnt == EP6_DEPTH);
    assign ep6_wr        = sel_ep6 && !nSLWR;
    assign ep6_wr_ok     = ep6_wr && !ep6_full;
    assign ep6_pkt       = sel_ep6 && !nPKTEND;
    assign ep6_pop       = host_ep6_rd_en && (ep6_cmt != '0);
    assign ep6_unc       = ep6_cnt - ep6_cmt;
    assign ep6_unc_after = ep6_unc + {{EP6_AW{1'b0}}, ep6_wr_ok};

    // Words released to the host this edge: short-packet commit or full packet
    always_comb begin
        ep6_add = '0;
        if (ep6_pkt && ep6_unc_after != '0)
            ep6_add = ep6_unc_after;
        else if (ep6_wr_ok && ep6_unc_after == PKT_W)
            ep6_add = PKT_W;
    end

    assign FLAGA              = (ep6_cnt == '0);
    assign FLAGB              = ep6_full;
    assign FLAGC              = ep2_empty;
    assign host_ep2_full      = ep2_full;
    assign host_ep6_committed = ep6_cmt;

    // EP2 storage array (no reset on data)
    always_ff @(posedge IFCLK) begin
        if (ep2_push)
            ep2_mem[ep2_wp] <= host_ep2_din;
    end

    // EP2 pointers, count and underflow flag
    always_ff @(posedge IFCLK) begin
        if (!nRST) begin
            ep2_wp      <= '0;
            ep2_rp      <= '0;
            ep2_cnt     <= '0;
            err_ep2_udf <= 1'b0;
        end else begin
            if (ep2_push)
                ep2_wp <= ep2_wp + 1'b1;
            if (ep2_pop)
                ep2_rp <= ep2_rp + 1'b1;
            if (ep2_push && !ep2_pop)
                ep2_cnt <= ep2_cnt + 1'b1;
            else if (!ep2_push && ep2_pop)
                ep2_cnt <= ep2_cnt - 1'b1;
            if (ep2_rd && ep2_empty)
                err_ep2_udf <= 1'b1;
        end
    end

    // EP6 storage array (no reset on data)
    always_ff @(posedge IFCLK) begin
        if (ep6_wr_ok)
            ep6_mem[ep6_wp] <= ep6_din;
    end

    // EP6 pointers, counters, commit and overflow flag
    always_ff @(posedge IFCLK) begin
        if (!nRST) begin
            ep6_wp      <= '0;
            ep6_rp      <= '0;
            ep6_cnt     <= '0;
            ep6_cmt     <= '0;
            err_ep6_ovf <= 1'b0;
        end else begin
            if (ep6_wr_ok)
                ep6_wp <= ep6_wp + 1'b1;
            if (ep6_pop)
                ep6_rp <= ep6_rp + 1'b1;
            ep6_cnt <= ep6_cnt + {{EP6_AW{1'b0}}, ep6_wr_ok}
                               - {{EP6_AW{1'b0}}, ep6_pop};
            ep6_cmt <= ep6_cmt + ep6_add
                               - {{EP6_AW{1'b0}}, ep6_pop};
            if (ep6_wr && ep6_full)
                err_ep6_ovf <= 1'b1;
        end
    end

    // Registered host read port, one-cycle valid per pop
    always_ff @(posedge IFCLK) begin
        if (!nRST) begin
            host_ep6_dout  <= '0;
            host_ep6_valid <= 1'b0;
        end else begin
            host_ep6_valid <= ep6_pop;
            if (ep6_pop)
                host_ep6_dout <= ep6_mem[ep6_rp];
        end
    end

endmodule
